// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: bursts of num_cycles SCLK periods at a programmable
// half-period with CPOL/CPHA-aware sample/shift strobes. Optional hold input under SPI_SCLK_HOLD_EN.
module spi_sclk_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rstn,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             cpol,
    input  logic             cpha,
`ifdef SPI_SCLK_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             sample_stb,
    output logic             shift_stb
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] hc_q, hc_d;
    logic [CNT_W:0]   ec_q, ec_d;
    logic [DIV_W-1:0] div_l_q, div_l_d;
    logic [CNT_W-1:0] n_l_q, n_l_d;
    logic             cpol_l_q, cpol_l_d;
    logic             cpha_l_q, cpha_l_d;
    logic             sclk_q, sclk_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zdone_q, zdone_d;
    logic             sample_q, sample_d;
    logic             shift_q, shift_d;
    logic             hold_act;

    always_comb begin
`ifdef SPI_SCLK_HOLD_EN
        hold_act = hold;
`else
        hold_act = 1'b0;
`endif
        state_d  = state_q;
        hc_d     = hc_q;
        ec_d     = ec_q;
        div_l_d  = div_l_q;
        n_l_d    = n_l_q;
        cpol_l_d = cpol_l_q;
        cpha_l_d = cpha_l_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        // A zero-length burst reports done one cycle after acceptance.
        done_d   = zdone_q;
        zdone_d  = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                busy_d = 1'b0;
                if (start) begin
                    if (num_cycles != '0) begin
                        div_l_d  = (div == '0) ? DIV_W'(1) : div;
                        n_l_d    = num_cycles;
                        cpol_l_d = cpol;
                        cpha_l_d = cpha;
                        hc_d     = '0;
                        ec_d     = '0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!hold_act) begin
                    if (hc_q == div_l_q - DIV_W'(1)) begin
                        hc_d   = '0;
                        ec_d   = ec_q + (CNT_W+1)'(1);
                        sclk_d = ~sclk_q;
                        // Even edge count before the toggle means a leading edge.
                        if (!ec_q[0]) begin
                            sample_d = ~cpha_l_q;
                            shift_d  = cpha_l_q;
                        end else begin
                            sample_d = cpha_l_q;
                            shift_d  = ~cpha_l_q;
                        end
                        if (ec_d == {n_l_q, 1'b0}) begin
                            sclk_d  = cpol_l_q;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        hc_d = hc_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            hc_q     <= '0;
            ec_q     <= '0;
            div_l_q  <= '0;
            n_l_q    <= '0;
            cpol_l_q <= 1'b0;
            cpha_l_q <= 1'b0;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zdone_q  <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            ec_q     <= ec_d;
            div_l_q  <= div_l_d;
            n_l_q    <= n_l_d;
            cpol_l_q <= cpol_l_d;
            cpha_l_q <= cpha_l_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zdone_q  <= zdone_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sclk       = sclk_q;
    assign sample_stb = sample_q;
    assign shift_stb  = shift_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: directed and random bursts checked cycle by cycle against
// an arithmetic model of SCLK edge timing and strobe polarity.
module tb_spi_sclk_gen;

    logic        clk_in = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] div = '0;
    logic [7:0]  num_cycles = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        busy, done, sclk, sample_stb, shift_stb;

    int vectors = 0;
    int miscompares = 0;

    spi_sclk_gen #(.DIV_W(16), .CNT_W(8)) dut (
        .clk_in(clk_in), .rstn(rstn), .start(start), .div(div),
        .num_cycles(num_cycles), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SCLK_HOLD_EN
        .hold(1'b0),
`endif
        .busy(busy), .done(done), .sclk(sclk),
        .sample_stb(sample_stb), .shift_stb(shift_stb)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the accept edge of an N>0 burst.
    task automatic check_at(input int k, input int dl, input int n, input int cp, input int ph);
        int  total, j;
        bit  edge_now, lead;
        total    = 2 * n * dl;
        j        = k / dl;
        edge_now = (k > 0) && (k % dl == 0);
        lead     = (j % 2) == 1;
        chk($sformatf("sclk k=%0d", k), {31'b0, sclk}, 32'(cp ^ (j % 2)));
        chk($sformatf("sample k=%0d", k), {31'b0, sample_stb}, 32'(edge_now && (lead ? !ph : ph)));
        chk($sformatf("shift k=%0d", k), {31'b0, shift_stb}, 32'(edge_now && (lead ? ph : !ph)));
        chk($sformatf("done k=%0d", k), {31'b0, done}, 32'(k == total));
        chk($sformatf("busy k=%0d", k), {31'b0, busy}, 32'(k < total));
    endtask

    task automatic run_burst(input int d, input int n, input int cp, input int ph, input bit noise);
        int dl, total;
        dl = (d == 0) ? 1 : d;
        total = 2 * n * dl;
        start = 1'b1; div = 16'(d); num_cycles = 8'(n); cpol = cp[0]; cpha = ph[0];
        @(posedge clk_in); #1;
        start = 1'b0;
        if (n == 0) begin
            for (int k = 0; k <= 2; k++) begin
                chk($sformatf("zero sclk k=%0d", k), {31'b0, sclk}, 32'(cp));
                chk($sformatf("zero busy k=%0d", k), {31'b0, busy}, 32'd0);
                chk($sformatf("zero done k=%0d", k), {31'b0, done}, 32'(k == 1));
                chk($sformatf("zero stb k=%0d", k), {30'b0, sample_stb, shift_stb}, 32'd0);
                if (k < 2) begin @(posedge clk_in); #1; end
            end
        end else begin
            for (int k = 0; k <= total; k++) begin
                check_at(k, dl, n, cp, ph);
                if (k == total) break;
                if (noise) begin
                    start = 1'($urandom); div = 16'($urandom_range(0, 7));
                    num_cycles = 8'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
                end
                @(posedge clk_in); #1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset sclk", {31'b0, sclk}, 32'd0);
        chk("reset stb", {30'b0, sample_stb, shift_stb}, 32'd0);
        @(negedge clk_in); rstn = 1'b1;
        @(posedge clk_in); #1;

        run_burst(2, 2, 0, 0, 1'b0);
        run_burst(0, 3, 0, 1, 1'b0);
        run_burst(3, 1, 1, 1, 1'b0);
        run_burst(0, 0, 1, 0, 1'b0);
        run_burst(0, 0, 0, 1, 1'b0);
        run_burst(2, 2, 0, 0, 1'b1);
        run_burst(1, 255, 1, 0, 1'b0);

        // Reset mid-burst, then a fresh burst.
        begin
            start = 1'b1; div = 16'd2; num_cycles = 8'd2; cpol = 1'b0; cpha = 1'b0;
            @(posedge clk_in); #1;
            start = 1'b0;
            for (int k = 0; k <= 3; k++) begin
                check_at(k, 2, 2, 0, 0);
                if (k < 3) begin @(posedge clk_in); #1; end
            end
            rstn = 1'b0; #1;
            chk("abort sclk", {31'b0, sclk}, 32'd0);
            chk("abort busy", {31'b0, busy}, 32'd0);
            for (int k = 0; k < 6; k++) begin
                @(posedge clk_in); #1;
                chk("abort no done", {31'b0, done}, 32'd0);
                chk("abort no stb", {30'b0, sample_stb, shift_stb}, 32'd0);
            end
            @(negedge clk_in); rstn = 1'b1;
            @(posedge clk_in); #1;
            run_burst(2, 2, 0, 0, 1'b0);
        end

        for (int i = 0; i < 24; i++)
            run_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator, successor to the fixed 32-bit free-running clock divider. It produces a burst of exactly N SCLK cycles at a programmable half-period. It supports all four CPOL/CPHA modes and gives single-cycle sample/shift strobes in the clk_in domain. It sits between the SPI master control FSM (start/done handshake) and the shift register / pad logic.

Parameters:
DIV_W, 16, width of half-period divisor input div
CNT_W, 8, width of burst length input num_cycles (max 2^CNT_W-1 SCLK cycles per burst)

Ports:
clk_in  input  1  system clock
rstn  input  1  asynchronous active-low reset
start  input  1  burst request; accepted only when busy=0
div  input  DIV_W  SCLK half-period in clk_in cycles; 0 treated as 1
num_cycles  input  CNT_W  SCLK cycles in burst
cpol  input  1  SCLK idle level
cpha  input  1  0: sample leading/shift trailing; 1: shift leading/sample trailing
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst end
sclk  output  1  serial clock, registered
sample_stb  output  1  one-cycle pulse coincident with sampling edge
shift_stb  output  1  one-cycle pulse coincident with shifting edge

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE; busy=0, done=0, sclk=0, sample_stb=0, shift_stb=0; all counters=0.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE: sclk<=cpol every cycle. Strobes are 0.
- start=1 in IDLE, num_cycles!=0:
  - latch div_l=max(div,1), n_l=num_cycles, cpol_l, cpha_l;
  - go to RUN; busy=1 from the next cycle.
  - Input changes while busy are ignored.
- start=1 in IDLE, num_cycles=0: no edges; done=1 for one cycle next cycle; busy stays 0.
- start while busy=1: ignored, not queued.
- RUN:
  - Half-period counter hc counts 0..div_l-1. At hc=div_l-1: sclk toggles, hc<=0, edge counter ec increments.
  - An edge with ec even is a leading edge (sclk leaves cpol_l). An edge with ec odd is a trailing edge.
  - Leading edge: cpha_l=0 -> sample_stb=1; cpha_l=1 -> shift_stb=1. Trailing edge: the opposite strobe.
  - A strobe is asserted in the same cycle the new sclk value appears.
- First edge appears div_l cycles after the start-accept edge.
- Final (2*n_l-th) edge, all in the same cycle: sclk returns to cpol_l, the corresponding strobe=1, done=1, busy=0, state IDLE.
- A new start may be accepted in the cycle done is high (busy=0); back-to-back bursts are permitted.
- Burst length from accept to done: exactly 2*n_l*div_l cycles.
- Width rules: ec is CNT_W+1 bits; hc is DIV_W bits; no wrap for any legal input.
- Reset mid-burst: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro: SPI_SCLK_HOLD_EN.
- Defined: extra input port hold (1 bit). While hold=1 in RUN:
  - hc and ec freeze, sclk holds its level, strobes forced 0;
  - counting resumes the cycle after hold falls;
  - each hold cycle extends the burst by exactly one cycle;
  - hold has no effect in IDLE.
- Undefined: port absent; behaviour as above.

Test Plan:
- cpol=0, cpha=0, div=2, N=2, start accepted at T -> sclk rises T+2, falls T+4, rises T+6, falls T+8; sample_stb at T+2,T+6; shift_stb at T+4,T+8; done=1 and busy=0 at T+8.
- div=0, N=3, cpol=0, cpha=1 -> edges every cycle T+1..T+6; shift_stb at T+1,T+3,T+5; sample_stb at T+2,T+4,T+6; done at T+6.
- cpol=1, cpha=1, div=3, N=1 -> sclk=1 idle; falls T+3 with shift_stb; rises T+6 with sample_stb and done.
- num_cycles=0 start at T -> done=1 at T+1 only; busy stays 0; sclk stays at cpol; no strobes.
- Mid-burst: change div/cpol and pulse start -> timing unchanged from latched config, no second burst. rstn low at T+3 of the first scenario -> sclk=0, busy=0, no done; a fresh start after release completes normally.
- With SPI_SCLK_HOLD_EN, first scenario, hold=1 for 3 cycles after T+3 -> remaining edges shift by 3; done at T+11.
